superscalar_exec_stage: RTL and testbench
=========================================

// Module: superscalar_exec_stage
// PURPOSE
//  N-lane registered execute stage for the superscalar core. Takes one issue bundle per handshake, computes per-lane ALU results
//  (multi-cycle MUL), resolves branches/returns, and presents a result bundle plus at most one PC redirect to writeback/fetch.
//  Sits between operand-read/issue and writeback.
// PARAMETERS
//  LANES    2   issue width (lanes 0..LANES-1, lane 0 = oldest)
//  XLEN     32  datapath width (operands, results, PCs)
//  MUL_LAT  3   cycles from bundle accept to result when any lane is MUL (>=2)
// PORTS
//  clk           in   1            clock, all state on posedge
//  rst           in   1            asynchronous, active-high reset
//  flush         in   1            synchronous kill of held/in-flight bundle
//  in_valid      in   LANES        per-lane valid of issue bundle
//  in_ready      out  1            stage can accept a bundle this cycle
//  in_pc         in   LANES*XLEN   lane PCs (lane i at [i*XLEN+:XLEN])
//  in_opa        in   LANES*XLEN   operand A
//  in_opb        in   LANES*XLEN   operand B (immediate already selected)
//  in_alu_op     in   LANES*4      ALU opcode (package enum)
//  in_br_kind    in   LANES*2      0 none, 1 BEQ, 2 BGT, 3 RET
//  in_br_target  in   LANES*XLEN   branch target
//  out_valid     out  LANES        per-lane result valid
//  out_ready     in   1            consumer takes result bundle
//  out_result    out  LANES*XLEN   ALU results
//  redirect_valid out 1            one-cycle fetch redirect
//  redirect_pc   out  XLEN         redirect target
// BEHAVIOUR
//  Reset: state IDLE, out_valid=0, out_result=0, redirect_valid=0, redirect_pc=0, MUL counter=0; in_ready=1 after release.
//  Accept: fire = |in_valid & in_ready. Lanes with in_valid=0 are carried as bubbles (out_valid bit 0).
//  FSM: IDLE -fire, no MUL-> HOLD; IDLE -fire, any MUL-> MBUSY (counter=MUL_LAT-1);
//   MBUSY: decrement each cycle, at 1 -> HOLD (bundle visible MUL_LAT cycles after accept);
//   HOLD: out_valid per lane; out_ready=1 -> IDLE, or direct to HOLD/MBUSY if a new bundle fires same cycle.
//  in_ready = (state==IDLE) | (state==HOLD & out_ready); 0 in MBUSY. Non-MUL latency 1 cycle, full throughput.
//  ALU ops (mod 2^XLEN): ADD A+B, SUB A-B, CMP A-B, MUL low XLEN of A*B, MOV B, OR, AND, NOT ~A,
//   LSL A<<B[$clog2(XLEN)-1:0], LSR logical >>, ASR arithmetic >>; undefined opcodes -> result 0, no error.
//  Branch resolve (per valid lane): BEQ taken iff opa==opb; BGT taken iff $signed(opa)>$signed(opb);
//   RET always taken, target=opa; not-taken emits no redirect (predicted not-taken).
//  Priority: lowest-index taken lane wins; all higher lanes' out_valid forced 0 in that bundle (younger squashed).
//  redirect_valid=1 for exactly the cycle the winning bundle transfers (HOLD & out_ready), redirect_pc = its target.
//  flush (any state): bundle and MUL aborted, out_valid=0, redirect_valid=0 that cycle, state IDLE next cycle;
//   flush dominates a coincident fire (bundle dropped). rst mid-MUL: same as reset, no partial output.
//  Held outputs stable while out_valid & !out_ready.
// STRUCTURE
//  Package exec_pkg: alu_op_e (ADD=0 SUB=1 CMP=2 MUL=3 MOV=4 OR=5 AND=6 NOT=7 LSL=8 LSR=9 ASR=10),
//   br_kind_e (NONE/BEQ/BGT/RET), state_e (IDLE/MBUSY/HOLD).
//  Sub-module exec_lane (combinational ALU + branch resolve, one lane) instantiated per lane by generate;
//   MUL product registered in parent over MUL_LAT cycles; FSM, squash and redirect select in parent.
// TESTING
//  ADD lane0 5+7, SUB lane1 3-5 -> next cycle out_valid=11, results 12 and 0xFFFFFFFE, no redirect.
//  MUL 6*7 lane0 -> in_ready low MUL_LAT-1 cycles, result 42 visible exactly MUL_LAT cycles after accept.
//  BEQ lane0 opa=opb=9 target 0x100, ADD lane1 -> out_valid=01, redirect 0x100 one cycle; BGT -1>1 -> not taken.
//  RET lane1 opa=0x40, lane0 NOP -> out_valid=11, redirect_pc=0x40; both lanes taken -> lane0 target only.
//  out_ready=0 for 4 cycles in HOLD -> outputs stable, in_ready=0; release -> back-to-back bundle accepted same cycle.
//  flush during MBUSY and rst mid-MUL -> no out_valid, no redirect, in_ready=1 next cycle.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared types for the superscalar execute stage: ALU opcodes, branch kinds, FSM states.
package exec_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_CMP = 4'd2,
    ALU_MUL = 4'd3,
    ALU_MOV = 4'd4,
    ALU_OR  = 4'd5,
    ALU_AND = 4'd6,
    ALU_NOT = 4'd7,
    ALU_LSL = 4'd8,
    ALU_LSR = 4'd9,
    ALU_ASR = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_BEQ  = 2'd1,
    BR_BGT  = 2'd2,
    BR_RET  = 2'd3
  } br_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MBUSY = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  function automatic logic is_mul_op(input logic [3:0] op);
    return op == ALU_MUL;
  endfunction

endpackage

// File: rtl/superscalar_exec_stage_lane.sv
// One execute lane: combinational ALU plus branch resolution.
module exec_lane
  import exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_valid,
  input  logic [3:0]      i_alu_op,
  input  logic [1:0]      i_br_kind,
  input  logic [XLEN-1:0] i_opa,
  input  logic [XLEN-1:0] i_opb,
  input  logic [XLEN-1:0] i_br_target,
  output logic [XLEN-1:0] o_result,
  output logic            o_is_mul,
  output logic            o_taken,
  output logic [XLEN-1:0] o_target
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] w_shamt;
  logic           w_cond;

  assign w_shamt = i_opb[SHW-1:0];

  always_comb begin
    o_result = '0;
    case (alu_op_e'(i_alu_op))
      ALU_ADD: o_result = i_opa + i_opb;
      ALU_SUB: o_result = i_opa - i_opb;
      ALU_CMP: o_result = i_opa - i_opb;
      ALU_MUL: o_result = i_opa * i_opb;
      ALU_MOV: o_result = i_opb;
      ALU_OR:  o_result = i_opa | i_opb;
      ALU_AND: o_result = i_opa & i_opb;
      ALU_NOT: o_result = ~i_opa;
      ALU_LSL: o_result = i_opa << w_shamt;
      ALU_LSR: o_result = i_opa >> w_shamt;
      ALU_ASR: o_result = $signed(i_opa) >>> w_shamt;
      default: o_result = '0;
    endcase
  end

  always_comb begin
    w_cond = 1'b0;
    case (br_kind_e'(i_br_kind))
      BR_BEQ:  w_cond = (i_opa == i_opb);
      BR_BGT:  w_cond = ($signed(i_opa) > $signed(i_opb));
      BR_RET:  w_cond = 1'b1;
      default: w_cond = 1'b0;
    endcase
  end

  assign o_taken  = i_valid & w_cond;
  assign o_target = (br_kind_e'(i_br_kind) == BR_RET) ? i_opa : i_br_target;
  assign o_is_mul = i_valid & is_mul_op(i_alu_op);

endmodule

// File: rtl/superscalar_exec_stage.sv
// N-lane registered execute stage: holds one result bundle, stretches MUL bundles to MUL_LAT
// cycles, squashes lanes younger than the oldest taken branch and emits a single redirect.
module superscalar_exec_stage
  import exec_pkg::*;
#(
  parameter int LANES   = 2,
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [LANES-1:0]      in_valid,
  output logic                  in_ready,
  input  logic [LANES*XLEN-1:0] in_pc,
  input  logic [LANES*XLEN-1:0] in_opa,
  input  logic [LANES*XLEN-1:0] in_opb,
  input  logic [LANES*4-1:0]    in_alu_op,
  input  logic [LANES*2-1:0]    in_br_kind,
  input  logic [LANES*XLEN-1:0] in_br_target,
  output logic [LANES-1:0]      out_valid,
  input  logic                  out_ready,
  output logic [LANES*XLEN-1:0] out_result,
  output logic                  redirect_valid,
  output logic [XLEN-1:0]       redirect_pc
);

  localparam int CW = $clog2(MUL_LAT + 1);

  logic [LANES-1:0][XLEN-1:0] w_res;
  logic [LANES-1:0][XLEN-1:0] w_tgt;
  logic [LANES-1:0]           w_mul;
  logic [LANES-1:0]           w_taken;
  logic [LANES-1:0]           w_vld;
  logic                       w_redir_v;
  logic [XLEN-1:0]            w_redir_pc;
  logic                       w_fire;
  logic                       w_unused_pc;
  state_e                     w_state_nxt;
  logic [CW-1:0]              w_cnt_nxt;

  state_e                     r_state;
  logic [CW-1:0]              r_cnt;
  logic [LANES-1:0]           r_vld;
  logic [LANES-1:0][XLEN-1:0] r_res;
  logic                       r_redir_v;
  logic [XLEN-1:0]            r_redir_pc;

  // PCs are not needed: branch targets arrive precomputed.
  assign w_unused_pc = ^in_pc;

  genvar g;
  generate
    for (g = 0; g < LANES; g++) begin : g_lane
      exec_lane #(.XLEN(XLEN)) u_lane (
        .i_valid     (in_valid[g]),
        .i_alu_op    (in_alu_op[g*4 +: 4]),
        .i_br_kind   (in_br_kind[g*2 +: 2]),
        .i_opa       (in_opa[g*XLEN +: XLEN]),
        .i_opb       (in_opb[g*XLEN +: XLEN]),
        .i_br_target (in_br_target[g*XLEN +: XLEN]),
        .o_result    (w_res[g]),
        .o_is_mul    (w_mul[g]),
        .o_taken     (w_taken[g]),
        .o_target    (w_tgt[g])
      );
    end
  endgenerate

  // Walk oldest to youngest; the first taken lane stays valid, everything after it dies.
  always_comb begin
    w_vld      = '0;
    w_redir_v  = 1'b0;
    w_redir_pc = '0;
    for (int i = 0; i < LANES; i++) begin
      if (!w_redir_v) begin
        w_vld[i] = in_valid[i];
        if (w_taken[i]) begin
          w_redir_v  = 1'b1;
          w_redir_pc = w_tgt[i];
        end
      end
    end
  end

  assign in_ready = (r_state == ST_IDLE) | ((r_state == ST_HOLD) & out_ready);
  assign w_fire   = (|in_valid) & in_ready & ~flush;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_MBUSY: begin
        if (r_cnt <= CW'(1)) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      ST_HOLD: if (out_ready) w_state_nxt = ST_IDLE;
      default: ;
    endcase
    if (w_fire) begin
      w_state_nxt = (|w_mul) ? ST_MBUSY : ST_HOLD;
      w_cnt_nxt   = (|w_mul) ? CW'(MUL_LAT - 1) : '0;
    end
    if (flush) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld      <= '0;
      r_res      <= '0;
      r_redir_v  <= 1'b0;
      r_redir_pc <= '0;
    end else if (w_fire) begin
      r_vld      <= w_vld;
      r_res      <= w_res;
      r_redir_v  <= w_redir_v;
      r_redir_pc <= w_redir_pc;
    end
  end

  assign out_valid      = ((r_state == ST_HOLD) & ~flush) ? r_vld : '0;
  assign out_result     = r_res;
  assign redirect_valid = (r_state == ST_HOLD) & out_ready & r_redir_v & ~flush;
  assign redirect_pc    = r_redir_pc;

endmodule

// File: tb/tb_superscalar_exec_stage.sv
// Bench for superscalar_exec_stage: directed vector table, hand-written corner sequences,
// and random bundles checked against a spec-level model.
module tb_superscalar_exec_stage;

  localparam int LANES   = 2;
  localparam int XLEN    = 32;
  localparam int MUL_LAT = 3;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  flush;
  logic [LANES-1:0]      in_valid;
  logic                  in_ready;
  logic [LANES*XLEN-1:0] in_pc;
  logic [LANES*XLEN-1:0] in_opa;
  logic [LANES*XLEN-1:0] in_opb;
  logic [LANES*4-1:0]    in_alu_op;
  logic [LANES*2-1:0]    in_br_kind;
  logic [LANES*XLEN-1:0] in_br_target;
  logic [LANES-1:0]      out_valid;
  logic                  out_ready;
  logic [LANES*XLEN-1:0] out_result;
  logic                  redirect_valid;
  logic [XLEN-1:0]       redirect_pc;

  superscalar_exec_stage #(.LANES(LANES), .XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_opa(in_opa), .in_opb(in_opb), .in_alu_op(in_alu_op),
    .in_br_kind(in_br_kind), .in_br_target(in_br_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       v;
    logic [1:0][3:0]  op;
    logic [1:0][1:0]  kind;
    logic [1:0][31:0] a;
    logic [1:0][31:0] b;
    logic [1:0][31:0] t;
  } bundle_t;

  typedef struct {
    logic [1:0]       vld;
    logic [1:0][31:0] res;
    logic             rv;
    logic [31:0]      rpc;
    int               lat;
  } exp_t;

  typedef struct {
    bundle_t bd;
    exp_t    ex;
  } vec_t;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] wide;
    int          sh;
    sh = int'(b % 32);
    case (op)
      4'd0: return a + b;
      4'd1, 4'd2: return a - b;
      4'd3: begin wide = {32'd0, a} * {32'd0, b}; return wide[31:0]; end
      4'd4: return b;
      4'd5: return a | b;
      4'd6: return a & b;
      4'd7: return ~a;
      4'd8: return a << sh;
      4'd9: return a >> sh;
      4'd10: begin wide = {{32{a[31]}}, a} >> sh; return wide[31:0]; end
      default: return 32'd0;
    endcase
  endfunction

  function automatic exp_t ref_model(input bundle_t bd);
    exp_t e;
    bit   taken;
    e.vld = '0; e.rv = 1'b0; e.rpc = '0; e.lat = 1;
    for (int i = 0; i < LANES; i++) begin
      e.res[i] = ref_alu(bd.op[i], bd.a[i], bd.b[i]);
      if (bd.v[i] && bd.op[i] == 4'd3) e.lat = MUL_LAT;
    end
    for (int i = 0; i < LANES; i++) begin
      if (!bd.v[i] || e.rv) continue;
      e.vld[i] = 1'b1;
      case (bd.kind[i])
        2'd1: taken = (bd.a[i] == bd.b[i]);
        2'd2: taken = (int'(bd.a[i]) > int'(bd.b[i]));
        2'd3: taken = 1'b1;
        default: taken = 1'b0;
      endcase
      if (taken) begin
        e.rv  = 1'b1;
        e.rpc = (bd.kind[i] == 2'd3) ? bd.a[i] : bd.t[i];
      end
    end
    return e;
  endfunction

  function automatic vec_t mk(input logic [1:0] v,
      input logic [3:0] op0, input logic [1:0] k0, input logic [31:0] a0, b0, t0,
      input logic [3:0] op1, input logic [1:0] k1, input logic [31:0] a1, b1, t1,
      input logic [1:0] evld, input logic [31:0] er0, er1, input logic erv,
      input logic [31:0] erpc, input int elat);
    vec_t r;
    r.bd.v = v;
    r.bd.op[0] = op0; r.bd.kind[0] = k0; r.bd.a[0] = a0; r.bd.b[0] = b0; r.bd.t[0] = t0;
    r.bd.op[1] = op1; r.bd.kind[1] = k1; r.bd.a[1] = a1; r.bd.b[1] = b1; r.bd.t[1] = t1;
    r.ex.vld = evld; r.ex.res[0] = er0; r.ex.res[1] = er1;
    r.ex.rv = erv; r.ex.rpc = erpc; r.ex.lat = elat;
    return r;
  endfunction

  task automatic drive(input bundle_t bd);
    in_valid     = bd.v;
    in_alu_op    = bd.op;
    in_br_kind   = bd.kind;
    in_opa       = bd.a;
    in_opb       = bd.b;
    in_br_target = bd.t;
    in_pc        = {$urandom, $urandom};
  endtask

  // Entered and left just after a negedge with the stage idle.
  task automatic run_bundle(input bundle_t bd, input exp_t ex, input int stall, input string tag);
    int lat;
    drive(bd);
    out_ready = 1'b1;
    #1 chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid  = '0;
    out_ready = (stall == 0);
    #1;
    lat = 1;
    while (out_valid == '0 && lat < 12) begin
      chk({tag, " busy in_ready"}, 64'(in_ready), 64'd0);
      @(negedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'(ex.lat));
    for (int s = 0; s < stall; s++) begin
      chk({tag, " stall valid"}, 64'(out_valid), 64'(ex.vld));
      chk({tag, " stall redirect"}, 64'(redirect_valid), 64'd0);
      chk({tag, " stall in_ready"}, 64'(in_ready), 64'd0);
      @(negedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    chk({tag, " out_valid"}, 64'(out_valid), 64'(ex.vld));
    for (int i = 0; i < LANES; i++)
      if (ex.vld[i]) chk({tag, " result"}, 64'(out_result[i*XLEN +: XLEN]), 64'(ex.res[i]));
    chk({tag, " redirect_valid"}, 64'(redirect_valid), 64'(ex.rv));
    if (ex.rv) chk({tag, " redirect_pc"}, 64'(redirect_pc), 64'(ex.rpc));
    @(negedge clk); #1;
    chk({tag, " drained valid"}, 64'(out_valid), 64'd0);
    chk({tag, " drained redirect"}, 64'(redirect_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  vec_t    tbl[$];
  bundle_t bd;
  exp_t    ex;

  initial begin
    tbl.push_back(mk(2'b11, 4'd0,2'd0,32'd5,32'd7,32'd0,          4'd1,2'd0,32'd3,32'd5,32'd0,
                     2'b11, 32'd12, 32'hFFFFFFFE, 1'b0, 32'd0, 1));
    tbl.push_back(mk(2'b01, 4'd3,2'd0,32'd6,32'd7,32'd0,          4'd0,2'd0,32'd0,32'd0,32'd0,
                     2'b01, 32'd42, 32'd0, 1'b0, 32'd0, MUL_LAT));
    tbl.push_back(mk(2'b11, 4'd0,2'd1,32'd9,32'd9,32'h100,        4'd0,2'd0,32'd1,32'd1,32'd0,
                     2'b01, 32'd18, 32'd0, 1'b1, 32'h100, 1));
    tbl.push_back(mk(2'b11, 4'd0,2'd2,32'hFFFFFFFF,32'd1,32'h300, 4'd4,2'd0,32'd0,32'd5,32'd0,
                     2'b11, 32'd0, 32'd5, 1'b0, 32'd0, 1));
    tbl.push_back(mk(2'b11, 4'd0,2'd0,32'd0,32'd0,32'd0,          4'd0,2'd3,32'h40,32'd0,32'h999,
                     2'b11, 32'd0, 32'h40, 1'b1, 32'h40, 1));
    tbl.push_back(mk(2'b11, 4'd4,2'd3,32'h80,32'd3,32'h111,       4'd0,2'd1,32'd1,32'd1,32'h200,
                     2'b01, 32'd3, 32'd0, 1'b1, 32'h80, 1));
    tbl.push_back(mk(2'b11, 4'd10,2'd0,32'h80000000,32'd4,32'd0,  4'd9,2'd0,32'h80000000,32'd4,32'd0,
                     2'b11, 32'hF8000000, 32'h08000000, 1'b0, 32'd0, 1));
    tbl.push_back(mk(2'b11, 4'd8,2'd0,32'd1,32'd33,32'd0,         4'd7,2'd0,32'd0,32'd9,32'd0,
                     2'b11, 32'd2, 32'hFFFFFFFF, 1'b0, 32'd0, 1));
    tbl.push_back(mk(2'b11, 4'd5,2'd0,32'hF0,32'h0F,32'd0,        4'd6,2'd0,32'hF0,32'h3C,32'd0,
                     2'b11, 32'hFF, 32'h30, 1'b0, 32'd0, 1));
    tbl.push_back(mk(2'b11, 4'd15,2'd0,32'd5,32'd6,32'd0,         4'd2,2'd0,32'd5,32'd5,32'd0,
                     2'b11, 32'd0, 32'd0, 1'b0, 32'd0, 1));
    tbl.push_back(mk(2'b11, 4'd3,2'd0,32'h10000,32'h10000,32'd0,  4'd3,2'd0,32'hFFFF,32'h10001,32'd0,
                     2'b11, 32'd0, 32'hFFFFFFFF, 1'b0, 32'd0, MUL_LAT));
    tbl.push_back(mk(2'b10, 4'd0,2'd1,32'd1,32'd1,32'h500,        4'd1,2'd2,32'd5,32'd3,32'h600,
                     2'b10, 32'd0, 32'd2, 1'b1, 32'h600, 1));
    tbl.push_back(mk(2'b01, 4'd0,2'd0,32'd2,32'd3,32'd0,          4'd3,2'd0,32'd4,32'd4,32'd0,
                     2'b01, 32'd5, 32'd0, 1'b0, 32'd0, 1));

    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    in_valid = '0; in_pc = '0; in_opa = '0; in_opb = '0;
    in_alu_op = '0; in_br_kind = '0; in_br_target = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset out_result", 64'(out_result), 64'd0);
    chk("reset redirect_valid", 64'(redirect_valid), 64'd0);
    chk("reset redirect_pc", 64'(redirect_pc), 64'd0);
    chk("reset in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    foreach (tbl[i]) run_bundle(tbl[i].bd, tbl[i].ex, i % 3, $sformatf("vec%0d", i));

    // Four-cycle backpressure, then a new bundle accepted in the same cycle the old one leaves.
    bd = tbl[0].bd;
    drive(bd);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = '0;
    for (int s = 0; s < 4; s++) begin
      #1;
      chk("hold valid", 64'(out_valid), 64'd3);
      chk("hold result", 64'(out_result), {32'hFFFFFFFE, 32'd12});
      chk("hold in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    bd = tbl[9].bd;
    bd.v = 2'b10;
    drive(bd);
    out_ready = 1'b1;
    #1;
    chk("b2b in_ready", 64'(in_ready), 64'd1);
    chk("b2b old valid", 64'(out_valid), 64'd3);
    @(negedge clk);
    in_valid = '0;
    #1;
    chk("b2b new valid", 64'(out_valid), 64'd2);
    chk("b2b new result", 64'(out_result[XLEN +: XLEN]), 64'd0);
    @(negedge clk);

    // Flush while a MUL is in flight.
    drive(tbl[1].bd);
    @(negedge clk);
    in_valid = '0;
    flush = 1'b1;
    #1;
    chk("flush mbusy valid", 64'(out_valid), 64'd0);
    chk("flush mbusy redirect", 64'(redirect_valid), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    #1 chk("flush mbusy in_ready", 64'(in_ready), 64'd1);
    for (int s = 0; s < MUL_LAT + 1; s++) begin
      chk("flush mbusy quiet", 64'(out_valid), 64'd0);
      @(negedge clk); #1;
    end

    // Flush coinciding with an accept drops the bundle.
    drive(tbl[0].bd);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    in_valid = '0;
    for (int s = 0; s < 3; s++) begin
      #1 chk("flush fire quiet", 64'(out_valid), 64'd0);
      @(negedge clk);
    end

    // Flush in HOLD suppresses a pending redirect even with out_ready high.
    drive(tbl[2].bd);
    @(negedge clk);
    in_valid  = '0;
    out_ready = 1'b0;
    #1 chk("flush hold pre valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    flush = 1'b1;
    #1;
    chk("flush hold valid", 64'(out_valid), 64'd0);
    chk("flush hold redirect", 64'(redirect_valid), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush hold after", 64'(out_valid), 64'd0);
    chk("flush hold in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    // Reset in the middle of a MUL.
    drive(tbl[10].bd);
    @(negedge clk);
    in_valid = '0;
    rst = 1'b1;
    #1;
    chk("rst mul valid", 64'(out_valid), 64'd0);
    chk("rst mul redirect", 64'(redirect_valid), 64'd0);
    chk("rst mul result", 64'(out_result), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rst mul in_ready", 64'(in_ready), 64'd1);
    for (int s = 0; s < MUL_LAT + 1; s++) begin
      chk("rst mul quiet", 64'(out_valid), 64'd0);
      @(negedge clk); #1;
    end

    // Random bundles against the reference model.
    for (int n = 0; n < 200; n++) begin
      bd.v = 2'($urandom_range(1, 3));
      for (int i = 0; i < LANES; i++) begin
        bd.op[i]   = ($urandom_range(0, 3) == 0) ? 4'd3 : 4'($urandom_range(0, 15));
        bd.kind[i] = 2'($urandom_range(0, 3));
        bd.a[i]    = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 20));
        bd.b[i]    = ($urandom_range(0, 2) == 0) ? bd.a[i] : (($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 40)));
        bd.t[i]    = $urandom;
      end
      ex = ref_model(bd);
      run_bundle(bd, ex, $urandom_range(0, 2), $sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
